sdram_port_arbiter: RTL and testbench

Round-robin arbiter between NR_PORTS wb_port instances and the single SDRAM controller core, in the SDRAM clock domain. Each port's internal access interface is multiplexed onto one controller-facing interface. Read-back data and address are broadcast from the controller to every port. After a read is acknowledged, the grant is held for a programmable window so that the granted port can issue its second, back-to-back burst request without losing the controller.

---
 rtl/sdram_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: arbitrates NR_PORTS upstream access ports onto a single
// SDRAM controller interface. After a read ack the owner keeps the grant for
// up to HOLD_CYCLES cycles so it can issue a back-to-back burst.
// Build option: define SDRAM_ARB_FIXED_PRIO_EN for lowest-index fixed priority
// (no rotation state); otherwise round-robin starting after the last owner.
module sdram_port_arbiter #(
    parameter int NR_PORTS    = 2,
    parameter int HOLD_CYCLES = 8,
    parameter int RR_W        = 3
) (
    input  logic                     sdram_clk,
    input  logic                     sdram_rst_n,
    input  logic [NR_PORTS-1:0]      port_acc_i,
    input  logic [NR_PORTS-1:0]      port_we_i,
    input  logic [32*NR_PORTS-1:0]   port_adr_i,
    input  logic [16*NR_PORTS-1:0]   port_dat_i,
    input  logic [2*NR_PORTS-1:0]    port_sel_i,
    output logic [NR_PORTS-1:0]      port_ack_o,
    output logic [31:0]              port_adr_o,
    output logic [15:0]              port_dat_o,
    output logic [31:0]              adr_o,
    output logic [15:0]              dat_o,
    output logic [1:0]               sel_o,
    output logic                     we_o,
    output logic                     acc_o,
    input  logic                     ack_i,
    input  logic [31:0]              adr_i,
    input  logic [15:0]              dat_i,
    output logic [NR_PORTS-1:0]      grant_o
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [RR_W-1:0]     owner_q, owner_d;
    logic [NR_PORTS-1:0] grant_q, grant_d;
    logic [7:0]          hold_cnt_q, hold_cnt_d;
    logic                go_idle;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    logic [RR_W-1:0]     last_q, last_d;
`endif

    logic [RR_W-1:0]     winner;
    logic                own_acc, own_we;
    logic [31:0]         own_adr;
    logic [15:0]         own_dat;
    logic [1:0]          own_sel;
    logic                in_grant;

    // Select the current owner's request signals.
    always_comb begin
        own_acc = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        for (int k = 0; k < NR_PORTS; k++) begin
            if (owner_q == RR_W'(k)) begin
                own_acc = port_acc_i[k];
                own_we  = port_we_i[k];
                own_adr = port_adr_i[32*k +: 32];
                own_dat = port_dat_i[16*k +: 16];
                own_sel = port_sel_i[2*k +: 2];
            end
        end
    end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    // Pick the lowest-indexed requesting port.
    always_comb begin
        winner = '0;
        for (int k = NR_PORTS - 1; k >= 0; k--) begin
            if (port_acc_i[k]) winner = RR_W'(k);
        end
    end
`else
    // Pick the first requesting port scanning upward from last+1, wrapping.
    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NR_PORTS; i++) begin
            idx = int'(last_q) + i;
            if (idx >= NR_PORTS) idx = idx - NR_PORTS;
            for (int k = 0; k < NR_PORTS; k++) begin
                if (!found && (k == idx) && port_acc_i[k]) begin
                    winner = RR_W'(k);
                    found  = 1'b1;
                end
            end
        end
    end
`endif

    // Next-state logic for the ownership FSM and hold counter.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        hold_cnt_d = hold_cnt_q;
        go_idle    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|port_acc_i) begin
                    state_d = S_GRANT;
                    owner_d = winner;
                    for (int k = 0; k < NR_PORTS; k++) begin
                        grant_d[k] = (winner == RR_W'(k));
                    end
                end
            end
            S_GRANT: begin
                if (ack_i) begin
                    if (own_we) begin
                        go_idle = 1'b1;
                    end else begin
                        state_d    = S_HOLD;
                        hold_cnt_d = 8'(HOLD_CYCLES - 1);
                    end
                end else if (!own_acc) begin
                    go_idle = 1'b1;
                end
            end
            S_HOLD: begin
                // An owner re-request wins even on the cycle the count expires.
                if (own_acc) begin
                    state_d = S_GRANT;
                end else if (hold_cnt_q == 8'd0) begin
                    go_idle = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase
        if (go_idle) begin
            state_d = S_IDLE;
            grant_d = '0;
        end
    end

`ifndef SDRAM_ARB_FIXED_PRIO_EN
    // Remember the port that most recently released the controller.
    always_comb begin
        last_d = go_idle ? owner_q : last_q;
    end
`endif

    // State registers; last resets to NR_PORTS-1 so port 0 wins first.
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            grant_q    <= '0;
            hold_cnt_q <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            last_q     <= RR_W'(NR_PORTS - 1);
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            hold_cnt_q <= hold_cnt_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            last_q     <= last_d;
`endif
        end
    end

    assign in_grant   = (state_q == S_GRANT);
    assign acc_o      = in_grant & own_acc;
    assign we_o       = in_grant & own_we;
    assign adr_o      = in_grant ? own_adr : '0;
    assign dat_o      = in_grant ? own_dat : '0;
    assign sel_o      = in_grant ? own_sel : '0;
    assign port_ack_o = (in_grant && ack_i) ? grant_q : '0;
    assign grant_o    = grant_q;
    assign port_adr_o = adr_i;
    assign port_dat_o = dat_i;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter (NR_PORTS=2, HOLD_CYCLES=8).
module tb_sdram_port_arbiter;

    localparam int NP = 2;
    localparam int HC = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NP-1:0]   port_acc = '0;
    logic [NP-1:0]   port_we = '0;
    logic [32*NP-1:0] port_adr = '0;
    logic [16*NP-1:0] port_dat = '0;
    logic [2*NP-1:0] port_sel = '0;
    logic [NP-1:0]   port_ack_o;
    logic [31:0]     port_adr_o;
    logic [15:0]     port_dat_o;
    logic [31:0]     adr_o;
    logic [15:0]     dat_o;
    logic [1:0]      sel_o;
    logic            we_o;
    logic            acc_o;
    logic            ack_i = 1'b0;
    logic [31:0]     adr_i = 32'h0000_0040;
    logic [15:0]     dat_i = 16'h1234;
    logic [NP-1:0]   grant_o;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.NR_PORTS(NP), .HOLD_CYCLES(HC), .RR_W(3)) dut (
        .sdram_clk   (clk),
        .sdram_rst_n (rst_n),
        .port_acc_i  (port_acc),
        .port_we_i   (port_we),
        .port_adr_i  (port_adr),
        .port_dat_i  (port_dat),
        .port_sel_i  (port_sel),
        .port_ack_o  (port_ack_o),
        .port_adr_o  (port_adr_o),
        .port_dat_o  (port_dat_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .sel_o       (sel_o),
        .we_o        (we_o),
        .acc_o       (acc_o),
        .ack_i       (ack_i),
        .adr_i       (adr_i),
        .dat_i       (dat_i),
        .grant_o     (grant_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] gq[$];
    logic [1:0]  aq[$];
    logic        acc_prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [1:0] g, input logic [31:0] a,
                                       input logic [15:0] d, input logic w, input logic [1:0] s);
        return {11'b0, g, a, d, w, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int k, input logic acc, input logic we,
                            input logic [31:0] a, input logic [15:0] d, input logic [1:0] s);
        port_acc[k]          = acc;
        port_we[k]           = we;
        port_adr[32*k +: 32] = a;
        port_dat[16*k +: 16] = d;
        port_sel[2*k +: 2]   = s;
    endtask

    function automatic int exp_owner(input int i);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        return 0;
`else
        return i % 2;
`endif
    endfunction

    // Monitor: every new controller access and every forwarded ack is matched
    // against the next expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (acc_o && !acc_prev) begin
                n_tests++;
                if (gq.size() == 0) begin
                    n_fail++;
                    $display("FAIL grant_unexpected: got grant=%b adr=%h", grant_o, adr_o);
                end else begin
                    n_tests--;
                    chk("grant_rec", {11'b0, grant_o, adr_o, dat_o, we_o, sel_o}, gq.pop_front());
                end
            end
            if (port_ack_o != '0) begin
                n_tests++;
                if (aq.size() == 0) begin
                    n_fail++;
                    $display("FAIL ack_unexpected: got %b, expected none", port_ack_o);
                end else begin
                    n_tests--;
                    chk("ack_rec", 64'(port_ack_o), 64'(aq.pop_front()));
                end
            end
            acc_prev = acc_o;
        end
    end

    logic [63:0] p0w, p1w;

    initial begin
        p0w = mk(2'b01, 32'h0000_2000, 16'h1111, 1'b1, 2'b01);
        p1w = mk(2'b10, 32'h0000_1004, 16'hBEEF, 1'b1, 2'b11);

        // Reset state and broadcast while in reset
        repeat (2) tick();
        chk("rst_grant", 64'(grant_o), 0);
        chk("rst_acc", 64'(acc_o), 0);
        chk("bcast_rst_dat", 64'(port_dat_o), 64'h1234);
        chk("bcast_rst_adr", 64'(port_adr_o), 64'h40);
        rst_n = 1'b1;
        adr_i = 32'hABCD_0000;
        dat_i = 16'h9999;
        tick();

        // Single write from port 1
        set_port(1, 1'b1, 1'b1, 32'h0000_1004, 16'hBEEF, 2'b11);
        gq.push_back(p1w);
        tick();
        chk("wr_acc", 64'(acc_o), 1);
        chk("wr_adr", 64'(adr_o), 64'h1004);
        chk("wr_dat", 64'(dat_o), 64'hBEEF);
        aq.push_back(2'b10);
        ack_i = 1'b1;
        #1;
        chk("wr_ack_comb", 64'(port_ack_o), 64'b10);
        tick();
        ack_i = 1'b0;
        port_acc[1] = 1'b0;
        chk("wr_idle", 64'(grant_o), 0);
        tick();

        // Asynchronous reset while port 1 owns
        port_acc[1] = 1'b1;
        gq.push_back(p1w);
        tick();
        chk("pre_rst_grant", 64'(grant_o), 64'b10);
        @(negedge clk);
        #1;
        ack_i = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_grant", 64'(grant_o), 0);
        chk("rst_async_acc", 64'(acc_o), 0);
        chk("rst_async_ack", 64'(port_ack_o), 0);
        ack_i = 1'b0;
        set_port(0, 1'b1, 1'b1, 32'h0000_2000, 16'h1111, 2'b01);
        tick();
        tick();
        chk("rst_held_grant", 64'(grant_o), 0);
        rst_n = 1'b1;
        gq.push_back(p0w);
        tick();
        chk("post_rst_p0", 64'(grant_o), 64'b01);

        // Round-robin with continuous writes, ack 3 cycles after each grant
        for (int i = 0; i < 4; i++) begin
            aq.push_back(exp_owner(i) == 0 ? 2'b01 : 2'b10);
            tick();
            tick();
            ack_i = 1'b1;
            tick();
            ack_i = 1'b0;
            if (i < 3) begin
                gq.push_back(exp_owner(i + 1) == 0 ? p0w : p1w);
                tick();
                chk("rr_grant", 64'(grant_o), exp_owner(i + 1) == 0 ? 64'b01 : 64'b10);
            end else begin
                port_acc = '0;
            end
        end
        tick();

        // Read with grant hold; port 1 requests a write throughout
        set_port(0, 1'b1, 1'b0, 32'h0000_3000, 16'h5555, 2'b11);
        set_port(1, 1'b1, 1'b1, 32'h0000_1004, 16'hBEEF, 2'b11);
        gq.push_back(mk(2'b01, 32'h0000_3000, 16'h5555, 1'b0, 2'b11));
        tick();
        chk("rd_grant", 64'(grant_o), 64'b01);
        aq.push_back(2'b01);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        port_acc[0] = 1'b0;
        chk("rd_hold_acc", 64'(acc_o), 0);
        chk("rd_hold_grant", 64'(grant_o), 64'b01);
        tick();
        tick();
        port_acc[0] = 1'b1;
        port_adr[31:0] = 32'h0000_3010;
        gq.push_back(mk(2'b01, 32'h0000_3010, 16'h5555, 1'b0, 2'b11));
        tick();
        chk("rd_regrant_acc", 64'(acc_o), 1);
        aq.push_back(2'b01);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        port_acc[0] = 1'b0;
        gq.push_back(p1w);
        repeat (HC - 1) tick();
        chk("rd_hold_keep", 64'(grant_o), 64'b01);
        tick();
        chk("rd_hold_expire", 64'(grant_o), 0);
        tick();
        chk("rd_then_p1", 64'(grant_o), 64'b10);
        aq.push_back(2'b10);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        port_acc = '0;
        tick();

        // Hold expiry with a stray ack, broadcast checked mid-HOLD
        set_port(0, 1'b1, 1'b0, 32'h0000_4000, 16'h0000, 2'b01);
        gq.push_back(mk(2'b01, 32'h0000_4000, 16'h0000, 1'b0, 2'b01));
        tick();
        aq.push_back(2'b01);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        port_acc = '0;
        tick();
        tick();
        ack_i = 1'b1;
        #1;
        chk("stray_ack", 64'(port_ack_o), 0);
        adr_i = 32'h0000_0040;
        dat_i = 16'h1234;
        #1;
        chk("bcast_hold_dat", 64'(port_dat_o), 64'h1234);
        chk("bcast_hold_adr", 64'(port_adr_o), 64'h40);
        tick();
        ack_i = 1'b0;
        repeat (HC - 4) tick();
        chk("hold_exp_keep", 64'(grant_o), 64'b01);
        tick();
        chk("hold_exp_idle", 64'(grant_o), 0);

        repeat (2) tick();
        chk("grant_queue_drained", 64'(gq.size()), 0);
        chk("ack_queue_drained", 64'(aq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
